period_scheduler: RTL and testbench
===================================

Name: period_scheduler

Overview:
- Sequences the school-day timetable from the hour/minute time base produced by the timer block.
- Holds a programmable table of NUM_PERIODS period start times and watches the 11-bit time word {hour[4:0], min[5:0]}.
- When the time reaches an enabled entry, it emits a one-cycle period_start pulse, latches the current period index, and drives a bell output for a fixed number of clocks.
- Seat-assignment logic downstream consumes period_idx and period_active.

Parameters:
- NUM_PERIODS, 8, number of table entries (2..16).
- IDX_W, 3, width of an entry index; must satisfy 2**IDX_W >= NUM_PERIODS.
- BELL_CYCLES, 4, clocks bell stays high after a fire (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  scheduler run enable.
- time_in  in  11  current time {hour[10:6], min[5:0]} from the timer.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IDX_W  entry to write.
- cfg_time  in  11  start time written to the entry.
- cfg_valid  in  1  entry enable bit written with the entry.
- period_start  out  1  one-cycle pulse on period entry.
- period_idx  out  IDX_W  index of the current or last period.
- period_active  out  1  a period has started since the last day wrap.
- bell  out  1  bell drive.
- multi_hit  out  1  sticky: more than one entry matched on the same tick.

Behaviour:
- Reset (async, rst=1):
  - All table entries are cleared to start 0, valid 0.
  - time_q is set to 0.
  - State goes to IDLE.
  - All outputs go to 0.
- Tick detection:
  - time_q is a registered copy of time_in, updated every cycle.
  - tick = (time_in != time_q).
  - Only ticks are evaluated, so one match fires once per time value, however many clocks that value persists.
- Match (without the optional feature): entry i hits when valid[i] && start[i] == time_in on a tick cycle. All entries are compared in parallel in one cycle.
- Winner and error flag:
  - The lowest-index hit wins.
  - If two or more entries hit, multi_hit is set and stays set until reset.
- States:
  - IDLE: enable=0. No fires; bell counter forced to 0; period_idx and period_active held. enable=1 moves to RUN on the next clock. time_q keeps tracking in IDLE, so no tick is generated on entry to RUN.
  - RUN: evaluates ticks.
    - A hit moves to FIRE.
    - enable=0 moves to IDLE.
    - A tick to time 00:00 (time_in==0) clears period_active, unless an entry also hits at 00:00, in which case the fire wins.
  - FIRE: lasts exactly one cycle.
    - period_start=1, period_idx<=winner, period_active<=1.
    - bell counter loaded with BELL_CYCLES.
    - Returns to RUN. A tick arriving during FIRE is still evaluated on that cycle and can fire again immediately after, with no tick lost.
- Latency: the time_in change is seen on clock edge N. period_start is high in cycle N+1, and bell is high from cycle N+1 for BELL_CYCLES cycles.
- Bell counter:
  - Decrements to 0 and does not wrap.
  - A new fire reloads it. Bell stays continuously high across back-to-back fires.
- Config writes:
  - Writes are accepted in any state and take effect at the clock edge.
  - A write in the same cycle as a tick does not affect that tick's compare; the old entry value is used.
  - cfg_addr >= NUM_PERIODS is ignored.
- enable falling during FIRE: the pulse still completes, then the block enters IDLE.
- Reset mid-bell or mid-FIRE: all outputs drop immediately, asynchronously.

Optional Feature:
- Macro: PERIOD_SCHED_CATCHUP_EN.
- When defined, a tick hits entry i if valid[i] and start[i] lies in the half-open window (time_q, time_in].
  - This catches periods skipped when the time base jumps by more than one minute (timer reload, slow clock).
  - If time_in < time_q (day wrap), the window is start > time_q OR start <= time_in.
  - Lowest-index-hit and multi_hit rules are unchanged; a multi-entry window sets multi_hit.
- When undefined, hits use exact equality only, as described under Behaviour.

Test Plan:
- Reset sequence:
  - Stimulus: program entry 2 = 08:30 valid, enable=1, step time_in 08:29 -> 08:30.
  - Required: period_start high exactly one cycle after the change, period_idx=2, period_active=1, bell high 4 cycles.
- Time value held:
  - Stimulus: hold time_in=08:30 for 100 clocks after the fire.
  - Required: no further period_start.
- Duplicate entries:
  - Stimulus: entries 1 and 5 both 10:00 valid, tick to 10:00.
  - Required: period_idx=1, multi_hit=1, and multi_hit stays 1 after further ticks until rst.
- Day wrap:
  - Stimulus: active period, tick 23:59 -> 00:00 with no entry at 00:00.
  - Required: period_active=0, period_idx unchanged, no pulse.
- Disabled, then write during tick:
  - Stimulus: with enable=0, tick to a valid entry time; then write that entry in the same cycle as a tick with enable=1.
  - Required: no fire while disabled; the write-cycle tick uses the old value.
- Catch-up (macro defined):
  - Stimulus: entry 3 = 09:15, jump time_in 09:10 -> 09:20.
  - Required: fire with period_idx=3. With the macro undefined, no fire.

Source files
------------

// File: rtl/period_scheduler.sv
// rtl/period_scheduler.sv - timetable sequencer firing period_start/bell on programmed start times.
// Optional window-match catch-up for skipped minutes: define PERIOD_SCHED_CATCHUP_EN.
module period_scheduler #(
  parameter int NUM_PERIODS = 8,
  parameter int IDX_W       = 3,
  parameter int BELL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [10:0]      time_in,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [10:0]      cfg_time,
  input  logic             cfg_valid,
  output logic             period_start,
  output logic [IDX_W-1:0] period_idx,
  output logic             period_active,
  output logic             bell,
  output logic             multi_hit
);

  typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;

  state_t                 state;
  logic [10:0]            start_t [NUM_PERIODS];
  logic [NUM_PERIODS-1:0] valid_t;
  logic [NUM_PERIODS-1:0] hit;
  logic [10:0]            time_q;
  logic [7:0]             bell_cnt;
  logic                   tick;
  logic                   any_hit;
  logic                   many_hit;
  logic [IDX_W-1:0]       winner;

  assign tick = (time_in != time_q);
  assign bell = (bell_cnt != 8'd0);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_PERIODS; i++) begin
`ifdef PERIOD_SCHED_CATCHUP_EN
      // Half-open window (time_q, time_in]; a backwards step means the day wrapped.
      if (time_in > time_q)
        hit[i] = valid_t[i] && (start_t[i] > time_q) && (start_t[i] <= time_in);
      else
        hit[i] = valid_t[i] && ((start_t[i] > time_q) || (start_t[i] <= time_in));
`else
      hit[i] = valid_t[i] && (start_t[i] == time_in);
`endif
    end
  end

  always_comb begin
    winner   = '0;
    any_hit  = 1'b0;
    many_hit = 1'b0;
    for (int i = 0; i < NUM_PERIODS; i++) begin
      if (hit[i]) begin
        if (any_hit) begin
          many_hit = 1'b1;
        end else begin
          winner  = IDX_W'(i);
          any_hit = 1'b1;
        end
      end
    end
  end

  // Entries beyond NUM_PERIODS have no storage, so such writes fall through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PERIODS; i++) start_t[i] <= '0;
      valid_t <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_PERIODS; i++) begin
        if (cfg_addr == IDX_W'(i)) begin
          start_t[i] <= cfg_time;
          valid_t[i] <= cfg_valid;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      time_q        <= '0;
      period_start  <= 1'b0;
      period_idx    <= '0;
      period_active <= 1'b0;
      bell_cnt      <= '0;
      multi_hit     <= 1'b0;
    end else begin
      time_q <= time_in;
      case (state)
        IDLE: begin
          period_start <= 1'b0;
          bell_cnt     <= '0;
          if (enable) state <= RUN;
        end
        default: begin
          // FIRE behaves like RUN for evaluation so a tick during the pulse is not lost.
          if (!enable) begin
            state        <= IDLE;
            period_start <= 1'b0;
            bell_cnt     <= (bell_cnt != 8'd0) ? bell_cnt - 8'd1 : 8'd0;
          end else if (tick && any_hit) begin
            state         <= FIRE;
            period_start  <= 1'b1;
            period_idx    <= winner;
            period_active <= 1'b1;
            bell_cnt      <= 8'(BELL_CYCLES);
            if (many_hit) multi_hit <= 1'b1;
          end else begin
            state        <= RUN;
            period_start <= 1'b0;
            bell_cnt     <= (bell_cnt != 8'd0) ? bell_cnt - 8'd1 : 8'd0;
            if (tick && (time_in == 11'd0)) period_active <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_scheduler.sv
// tb/tb_period_scheduler.sv - scoreboard bench for period_scheduler.
module tb_period_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] time_in = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [10:0] cfg_time = '0;
  logic        cfg_valid = 1'b0;
  logic        period_start;
  logic [2:0]  period_idx;
  logic        period_active;
  logic        bell;
  logic        multi_hit;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_q[$];
  int n;
  int base;

  period_scheduler #(.NUM_PERIODS(8), .IDX_W(3), .BELL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .time_in(time_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_time(cfg_time), .cfg_valid(cfg_valid),
    .period_start(period_start), .period_idx(period_idx), .period_active(period_active),
    .bell(bell), .multi_hit(multi_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] hm(input int h, input int m);
    return {5'(h), 6'(m)};
  endfunction

  task automatic cfg(input int addr, input logic [10:0] t, input logic v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_time = t; cfg_valid = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic step_to(input logic [10:0] t, input int wait_cycles);
    @(negedge clk);
    time_in = t;
    repeat (wait_cycles) @(negedge clk);
  endtask

  // Every period_start pulse must match the oldest expected fire index.
  always @(negedge clk) begin
    if (!rst && period_start) begin
      pulses++;
      if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
      else chk("start_idx", int'(period_idx), exp_q.pop_front());
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_start", int'(period_start), 0);
    chk("rst_idx", int'(period_idx), 0);
    chk("rst_active", int'(period_active), 0);
    chk("rst_bell", int'(bell), 0);
    chk("rst_multi", int'(multi_hit), 0);
    rst = 1'b0;

    cfg(2, hm(8, 30), 1'b1);
    step_to(hm(8, 29), 2);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(2);
    time_in = hm(8, 30);
    @(negedge clk);
    chk("fire_latency", int'(period_start), 1);
    chk("fire_active", int'(period_active), 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) chk("pulse_width", int'(period_start), 0);
      if (bell) n++;
      @(negedge clk);
    end
    chk("bell_len", n, 4);

    base = pulses;
    repeat (100) @(negedge clk);
    chk("hold_no_refire", pulses - base, 0);

    cfg(1, hm(10, 0), 1'b1);
    cfg(5, hm(10, 0), 1'b1);
    exp_q.push_back(1);
    step_to(hm(10, 0), 3);
    chk("dup_idx", int'(period_idx), 1);
    chk("dup_multi", int'(multi_hit), 1);
    step_to(hm(10, 1), 2);
    step_to(hm(10, 2), 2);
    chk("multi_sticky", int'(multi_hit), 1);

    base = pulses;
    step_to(hm(23, 59), 2);
    chk("pre_wrap_active", int'(period_active), 1);
    step_to(hm(0, 0), 3);
    chk("wrap_active", int'(period_active), 0);
    chk("wrap_idx", int'(period_idx), 1);
    chk("wrap_no_pulse", pulses - base, 0);

    enable = 1'b0;
    repeat (2) @(negedge clk);
    base = pulses;
    step_to(hm(8, 30), 3);
    step_to(hm(8, 0), 3);
    chk("disabled_no_fire", pulses - base, 0);
    chk("disabled_bell", int'(bell), 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(2);
    time_in = hm(8, 30);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_time = hm(8, 31); cfg_valid = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("old_value_fire", pulses - base, 1);
    exp_q.push_back(2);
    step_to(hm(8, 31), 3);
    chk("new_value_fire", pulses - base, 2);

    step_to(hm(9, 10), 3);
    cfg(3, hm(9, 15), 1'b1);
    base = pulses;
`ifdef PERIOD_SCHED_CATCHUP_EN
    exp_q.push_back(3);
    n = 1;
`else
    n = 0;
`endif
    step_to(hm(9, 20), 10);
    chk("catchup_fires", pulses - base, n);

    cfg(4, hm(9, 21), 1'b1);
    cfg(6, hm(9, 22), 1'b1);
    exp_q.push_back(4);
    exp_q.push_back(6);
    @(negedge clk);
    time_in = hm(9, 21);
    @(negedge clk);
    time_in = hm(9, 22);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bell) n++;
      @(negedge clk);
    end
    chk("b2b_bell_len", n, 5);
    chk("b2b_idx", int'(period_idx), 6);
    chk("multi_until_rst", int'(multi_hit), 1);

    cfg(7, hm(9, 23), 1'b1);
    exp_q.push_back(7);
    step_to(hm(9, 23), 1);
    chk("pre_rst_bell", int'(bell), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_bell", int'(bell), 0);
    chk("async_idx", int'(period_idx), 0);
    chk("async_active", int'(period_active), 0);
    chk("async_multi", int'(multi_hit), 0);
    chk("async_start", int'(period_start), 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
